// File: rtl/prgn_rr_scheduler.sv
// -----------------------------------------------------------------------------
// prgn_rr_scheduler
//
// Shares one pseudo-random number generator core among N_REQ requesters using
// round-robin arbitration. A granted requester supplies a 32-bit seed and a
// burst length. The scheduler loads the seed into the core, then issues one
// step per number. Each result is returned tagged with the owner's id. A
// watchdog aborts the burst when the core fails to answer a step in time.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   req_valid       per-requester pending request (held until accepted)
//   req_seed        packed seeds, slice i = [32*i +: 32]
//   req_len         packed burst lengths, slice i = [LEN_W*i +: LEN_W]
//   req_ready       one-hot accept, combinational, only while idle
//   core_load       one-cycle pulse loading core_seed into the core
//   core_seed       seed for the core, valid with core_load (0 otherwise)
//   core_step       one-cycle pulse requesting the next number
//   core_out_valid  core result strobe (only honoured while waiting)
//   core_rand       core result
//   rsp_valid       registered result pulse
//   rsp_id          owner of the current response / error
//   rsp_data        random number (holds when rsp_valid is low)
//   rsp_last        high with the final result of a burst
//   rsp_err         one-cycle pulse: burst aborted by the watchdog
//   busy            scheduler is not idle
// -----------------------------------------------------------------------------
module prgn_rr_scheduler #(
  parameter int N_REQ = 4,
  parameter int LEN_W = 8,
  parameter int TMO   = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [32*N_REQ-1:0]        req_seed,
  input  logic [LEN_W*N_REQ-1:0]     req_len,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       core_load,
  output logic [31:0]                core_seed,
  output logic                       core_step,
  input  logic                       core_out_valid,
  input  logic [31:0]                core_rand,
  output logic                       rsp_valid,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [31:0]                rsp_data,
  output logic                       rsp_last,
  output logic                       rsp_err,
  output logic                       busy
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int WD_W = $clog2(TMO);

  typedef enum logic [1:0] {IDLE, LOAD, STEP, WAIT} state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   last_grant_reg, last_grant_next;
  logic [ID_W-1:0]   id_reg, id_next;
  logic [31:0]       seed_reg, seed_next;
  logic [LEN_W-1:0]  remaining_reg, remaining_next;
  logic [WD_W-1:0]   wd_reg, wd_next;

  logic              rsp_valid_reg, rsp_valid_next;
  logic [ID_W-1:0]   rsp_id_reg, rsp_id_next;
  logic [31:0]       rsp_data_reg, rsp_data_next;
  logic              rsp_last_reg, rsp_last_next;
  logic              rsp_err_reg, rsp_err_next;

  // Unpacked views of the packed request buses.
  logic [31:0]       seed_arr [N_REQ];
  logic [LEN_W-1:0]  len_arr  [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign seed_arr[gi] = req_seed[32*gi +: 32];
      assign len_arr[gi]  = req_len[LEN_W*gi +: LEN_W];
    end
  endgenerate

  // Round-robin search starting one past the previous grant. Scanning offsets
  // 1..N_REQ means the previous winner is considered last.
  logic              grant_hit;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   cand_id;

  always_comb begin
    grant_hit = 1'b0;
    grant_idx = '0;
    cand_id   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_id = ID_W'((int'(last_grant_reg) + k) % N_REQ);
      if (!grant_hit && req_valid[cand_id]) begin
        grant_hit = 1'b1;
        grant_idx = cand_id;
      end
    end
  end

  // Ready is suppressed during reset so no request can appear accepted while
  // the block is held in its reset state.
  always_comb begin
    req_ready = '0;
    if (state_reg == IDLE && grant_hit && !rst) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  logic accept;
  assign accept = |(req_valid & req_ready);

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    id_next         = id_reg;
    seed_next       = seed_reg;
    remaining_next  = remaining_reg;
    wd_next         = wd_reg;
    rsp_valid_next  = 1'b0;
    rsp_last_next   = 1'b0;
    rsp_err_next    = 1'b0;
    rsp_id_next     = rsp_id_reg;
    rsp_data_next   = rsp_data_reg;
    core_load       = 1'b0;
    core_seed       = '0;
    core_step       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          last_grant_next = grant_idx;
          id_next         = grant_idx;
          seed_next       = seed_arr[grant_idx];
          remaining_next  = len_arr[grant_idx];
          // A zero-length request is consumed without touching the core.
          if (len_arr[grant_idx] != '0) begin
            state_next = LOAD;
          end
        end
      end
      LOAD: begin
        core_load  = 1'b1;
        core_seed  = seed_reg;
        state_next = STEP;
      end
      STEP: begin
        core_step  = 1'b1;
        wd_next    = '0;
        state_next = WAIT;
      end
      WAIT: begin
        // A result arriving on the final watchdog cycle still wins.
        if (core_out_valid) begin
          rsp_valid_next = 1'b1;
          rsp_data_next  = core_rand;
          rsp_id_next    = id_reg;
          remaining_next = remaining_reg - LEN_W'(1);
          if (remaining_reg == LEN_W'(1)) begin
            rsp_last_next = 1'b1;
            state_next    = IDLE;
          end else begin
            state_next = STEP;
          end
        end else if (wd_reg == WD_W'(TMO - 1)) begin
          rsp_err_next   = 1'b1;
          rsp_id_next    = id_reg;
          remaining_next = '0;
          state_next     = IDLE;
        end else begin
          wd_next = wd_reg + WD_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= ID_W'(N_REQ - 1);
      id_reg         <= '0;
      seed_reg       <= '0;
      remaining_reg  <= '0;
      wd_reg         <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_id_reg     <= '0;
      rsp_data_reg   <= '0;
      rsp_last_reg   <= 1'b0;
      rsp_err_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      id_reg         <= id_next;
      seed_reg       <= seed_next;
      remaining_reg  <= remaining_next;
      wd_reg         <= wd_next;
      rsp_valid_reg  <= rsp_valid_next;
      rsp_id_reg     <= rsp_id_next;
      rsp_data_reg   <= rsp_data_next;
      rsp_last_reg   <= rsp_last_next;
      rsp_err_reg    <= rsp_err_next;
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_last  = rsp_last_reg;
  assign rsp_err   = rsp_err_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_prgn_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_prgn_rr_scheduler
//
// Directed bench for the round-robin PRGN scheduler. A small core model
// answers each step a fixed number of cycles later with 0xC0DE0000 + step
// index. A negedge monitor logs grants, loads, steps, responses and errors
// with cycle stamps, and each test task checks those logs against
// hand-derived expectations.
// -----------------------------------------------------------------------------
module tb_prgn_rr_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_seed;
  logic [31:0]  req_len;
  logic [3:0]   req_ready;
  logic         core_load;
  logic [31:0]  core_seed;
  logic         core_step;
  logic         core_out_valid;
  logic [31:0]  core_rand;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_data;
  logic         rsp_last;
  logic         rsp_err;
  logic         busy;

  int total = 0;
  int bad   = 0;

  prgn_rr_scheduler #(.N_REQ(4), .LEN_W(8), .TMO(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_seed       (req_seed),
    .req_len        (req_len),
    .req_ready      (req_ready),
    .core_load      (core_load),
    .core_seed      (core_seed),
    .core_step      (core_step),
    .core_out_valid (core_out_valid),
    .core_rand      (core_rand),
    .rsp_valid      (rsp_valid),
    .rsp_id         (rsp_id),
    .rsp_data       (rsp_data),
    .rsp_last       (rsp_last),
    .rsp_err        (rsp_err),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // ---------------- core model ----------------
  logic        model_valid = 1'b0;
  logic [31:0] model_rand  = 32'h0;
  logic [31:0] model_pend  = 32'h0;
  int          model_cnt   = 0;
  int          model_steps = 0;
  int          core_lat    = 2;
  int          core_stop_at = 1000000;
  logic        spur_valid  = 1'b0;
  logic [31:0] spur_rand   = 32'h0;

  assign core_out_valid = model_valid | spur_valid;
  assign core_rand      = spur_valid ? spur_rand : model_rand;

  always @(negedge clk) begin
    model_valid = 1'b0;
    if (model_cnt == 1) begin
      model_valid = 1'b1;
      model_rand  = model_pend;
    end
    if (model_cnt > 0) model_cnt--;
    if (core_step) begin
      if (model_steps < core_stop_at) begin
        model_cnt  = core_lat;
        model_pend = 32'hC0DE_0000 + 32'(model_steps);
      end
      model_steps++;
    end
  end

  // ---------------- monitor ----------------
  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    logic        last;
    int          cyc;
  } rsp_t;

  int          cyc = 0;
  int          n_load = 0;
  int          load_cyc = 0;
  logic [31:0] last_seed = 32'h0;
  int          step_cyc [$];
  rsp_t        rsp_q [$];
  int          n_err = 0;
  int          err_cyc = 0;
  logic [1:0]  err_id = 2'd0;
  int          grant_q [$];
  int          grant_cyc [$];

  always @(negedge clk) begin
    rsp_t r;
    cyc++;
    if (core_load) begin
      n_load++;
      last_seed = core_seed;
      load_cyc  = cyc;
    end
    if (core_step) step_cyc.push_back(cyc);
    if (rsp_valid) begin
      r.id = rsp_id; r.data = rsp_data; r.last = rsp_last; r.cyc = cyc;
      rsp_q.push_back(r);
    end
    if (rsp_err) begin
      n_err++;
      err_cyc = cyc;
      err_id  = rsp_id;
    end
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        grant_q.push_back(i);
        grant_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [31:0] seed, input logic [7:0] len);
    req_seed[32*id +: 32] = seed;
    req_len[8*id +: 8]    = len;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (busy && n < max_cycles) begin
      tick();
      n++;
    end
    total++;
    if (busy) begin
      bad++;
      $display("FAIL idle_timeout busy=%0b after %0d cycles, required 0", busy, n);
    end
    // let the monitor log the final registered response
    tick();
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; req_valid = 4'h0; req_seed = '0; req_len = '0;
    repeat (3) tick();
    req_valid = 4'hF;
    #1;
    total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if ({rsp_valid, rsp_last, rsp_err} !== 3'b000) begin bad++; $display("FAIL reset_rsp_flags got=%b want=000", {rsp_valid, rsp_last, rsp_err}); end
    total++; if ({core_load, core_step} !== 2'b00 || core_seed !== 32'h0) begin bad++; $display("FAIL reset_core got=%b/%h want=00/0", {core_load, core_step}, core_seed); end
    total++; if (rsp_data !== 32'h0 || rsp_id !== 2'd0) begin bad++; $display("FAIL reset_rsp_data got=%h/%0d want=0/0", rsp_data, rsp_id); end
    req_valid = 4'h0;
    tick();
    rst = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_basic_burst();
    int g0 = grant_q.size();
    int r0 = rsp_q.size();
    int s0 = step_cyc.size();
    int l0 = n_load;
    int d0 = model_steps;
    int gc;
    set_req(0, 32'h0000_0001, 8'd3);
    req_valid[0] = 1'b1;
    tick();
    req_valid[0] = 1'b0;
    wait_idle(100);
    total++; if (grant_q.size() != g0 + 1) begin bad++; $display("FAIL basic_grants got=%0d want=1", grant_q.size() - g0); end
    if (grant_q.size() == g0 + 1) begin
      gc = grant_cyc[g0];
      total++; if (grant_q[g0] != 0) begin bad++; $display("FAIL basic_grant_id got=%0d want=0", grant_q[g0]); end
      total++; if (n_load - l0 != 1 || last_seed !== 32'h1) begin bad++; $display("FAIL basic_load got=%0d/%h want=1/00000001", n_load - l0, last_seed); end
      total++; if (load_cyc != gc + 1) begin bad++; $display("FAIL basic_load_lat got=%0d want=%0d", load_cyc, gc + 1); end
      total++; if (step_cyc.size() - s0 != 3) begin bad++; $display("FAIL basic_steps got=%0d want=3", step_cyc.size() - s0); end
      if (step_cyc.size() - s0 == 3) begin
        for (int k = 0; k < 3; k++) begin
          total++; if (step_cyc[s0+k] != gc + 2 + 3*k) begin bad++; $display("FAIL basic_step_cyc[%0d] got=%0d want=%0d", k, step_cyc[s0+k], gc + 2 + 3*k); end
        end
      end
      total++; if (rsp_q.size() - r0 != 3) begin bad++; $display("FAIL basic_rsp_count got=%0d want=3", rsp_q.size() - r0); end
      if (rsp_q.size() - r0 == 3) begin
        for (int k = 0; k < 3; k++) begin
          total++;
          if (rsp_q[r0+k].id !== 2'd0 || rsp_q[r0+k].data !== 32'hC0DE_0000 + 32'(d0 + k) ||
              rsp_q[r0+k].last !== (k == 2) || rsp_q[r0+k].cyc != gc + 5 + 3*k) begin
            bad++;
            $display("FAIL basic_rsp[%0d] got=id%0d %h last%0b c%0d want=id0 %h last%0b c%0d", k,
                     rsp_q[r0+k].id, rsp_q[r0+k].data, rsp_q[r0+k].last, rsp_q[r0+k].cyc,
                     32'hC0DE_0000 + 32'(d0 + k), (k == 2), gc + 5 + 3*k);
          end
        end
      end
    end
    $display("test_basic_burst done");
  endtask

  task automatic test_round_robin();
    int exp_order [5] = '{0, 1, 2, 3, 1};
    int g0, r0, seen, id;
    bit reraised = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    g0 = grant_q.size();
    r0 = rsp_q.size();
    seen = g0;
    for (int i = 0; i < 4; i++) set_req(i, 32'h100 + 32'(i), 8'd1);
    req_valid = 4'hF;
    for (int c = 0; c < 200 && !(seen >= g0 + 5 && !busy); c++) begin
      tick();
      while (seen < grant_q.size()) begin
        id = grant_q[seen];
        req_valid[id] = 1'b0;
        if (id == 1 && !reraised) begin
          req_valid[1] = 1'b1;
          reraised = 1'b1;
        end
        seen++;
      end
    end
    req_valid = 4'h0;
    wait_idle(50);
    total++; if (grant_q.size() - g0 != 5) begin bad++; $display("FAIL rr_grant_count got=%0d want=5", grant_q.size() - g0); end
    total++; if (rsp_q.size() - r0 != 5) begin bad++; $display("FAIL rr_rsp_count got=%0d want=5", rsp_q.size() - r0); end
    if (grant_q.size() - g0 == 5 && rsp_q.size() - r0 == 5) begin
      for (int k = 0; k < 5; k++) begin
        total++;
        if (grant_q[g0+k] != exp_order[k] || rsp_q[r0+k].id !== 2'(exp_order[k]) || rsp_q[r0+k].last !== 1'b1) begin
          bad++;
          $display("FAIL rr_order[%0d] got=grant%0d rsp%0d last%0b want=%0d/%0d/1", k,
                   grant_q[g0+k], rsp_q[r0+k].id, rsp_q[r0+k].last, exp_order[k], exp_order[k]);
        end
      end
    end
    $display("test_round_robin done");
  endtask

  task automatic test_zero_len();
    int g0 = grant_q.size();
    int r0 = rsp_q.size();
    int l0 = n_load;
    set_req(2, 32'h2222_2222, 8'd0);
    set_req(3, 32'h3333_0003, 8'd2);
    req_valid = 4'b1100;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL zl_ready_first got=%b want=0100", req_ready); end
    tick();
    req_valid[2] = 1'b0;
    #1;
    total++; if (req_ready !== 4'b1000 || busy !== 1'b0) begin bad++; $display("FAIL zl_ready_next got=%b busy%0b want=1000 busy0", req_ready, busy); end
    tick();
    req_valid[3] = 1'b0;
    wait_idle(100);
    total++; if (n_load - l0 != 1 || last_seed !== 32'h3333_0003) begin bad++; $display("FAIL zl_load got=%0d/%h want=1/33330003", n_load - l0, last_seed); end
    total++; if (grant_q.size() - g0 != 2) begin bad++; $display("FAIL zl_grants got=%0d want=2", grant_q.size() - g0); end
    else begin
      total++; if (grant_cyc[g0+1] != grant_cyc[g0] + 1) begin bad++; $display("FAIL zl_grant_gap got=%0d want=1", grant_cyc[g0+1] - grant_cyc[g0]); end
    end
    total++; if (rsp_q.size() - r0 != 2) begin bad++; $display("FAIL zl_rsp_count got=%0d want=2", rsp_q.size() - r0); end
    else begin
      total++; if (rsp_q[r0].id !== 2'd3 || rsp_q[r0+1].id !== 2'd3 || rsp_q[r0+1].last !== 1'b1) begin bad++; $display("FAIL zl_rsp_ids got=%0d,%0d last%0b want=3,3 last1", rsp_q[r0].id, rsp_q[r0+1].id, rsp_q[r0+1].last); end
    end
    $display("test_zero_len done");
  endtask

  task automatic test_timeout();
    int r0 = rsp_q.size();
    int s0 = step_cyc.size();
    int e0 = n_err;
    core_stop_at = model_steps + 1;
    set_req(0, 32'h4444_4444, 8'd3);
    req_valid[0] = 1'b1;
    tick();
    req_valid[0] = 1'b0;
    wait_idle(300);
    core_stop_at = 1000000;
    total++; if (step_cyc.size() - s0 != 2) begin bad++; $display("FAIL tmo_steps got=%0d want=2", step_cyc.size() - s0); end
    total++; if (rsp_q.size() - r0 != 1) begin bad++; $display("FAIL tmo_rsp_count got=%0d want=1", rsp_q.size() - r0); end
    else begin
      total++; if (rsp_q[r0].last !== 1'b0) begin bad++; $display("FAIL tmo_rsp_last got=%0b want=0", rsp_q[r0].last); end
    end
    total++; if (n_err - e0 != 1 || err_id !== 2'd0) begin bad++; $display("FAIL tmo_err got=%0d id%0d want=1 id0", n_err - e0, err_id); end
    if (step_cyc.size() - s0 == 2) begin
      total++; if (err_cyc != step_cyc[s0+1] + 65) begin bad++; $display("FAIL tmo_err_cyc got=%0d want=%0d", err_cyc, step_cyc[s0+1] + 65); end
    end
    $display("test_timeout done");
  endtask

  task automatic test_reset_midburst();
    int s0 = step_cyc.size();
    int r0;
    int n = 0;
    set_req(1, 32'h5555_5555, 8'd5);
    req_valid[1] = 1'b1;
    tick();
    req_valid[1] = 1'b0;
    while (step_cyc.size() == s0 && n < 20) begin
      tick();
      n++;
    end
    total++; if (step_cyc.size() == s0) begin bad++; $display("FAIL mid_no_step got=0 steps want>=1"); end
    rst = 1'b1;
    #1;
    r0 = rsp_q.size();
    total++; if (busy !== 1'b0 || core_step !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_ctrl got=busy%0b step%0b rv%0b want=000", busy, core_step, rsp_valid); end
    total++; if (rsp_data !== 32'h0 || rsp_id !== 2'd0) begin bad++; $display("FAIL mid_rst_data got=%h/%0d want=0/0", rsp_data, rsp_id); end
    tick();
    rst = 1'b0;
    repeat (5) tick();
    total++; if (rsp_q.size() != r0 || busy !== 1'b0) begin bad++; $display("FAIL mid_late_result got=rsp%0d busy%0b want=rsp0 busy0", rsp_q.size() - r0, busy); end
    set_req(0, 32'h0, 8'd0);
    set_req(3, 32'h0, 8'd0);
    req_valid = 4'b1001;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_next_grant got=%b want=0001", req_ready); end
    req_valid = 4'h0;
    tick();
    $display("test_reset_midburst done");
  endtask

  task automatic test_spurious();
    int r0 = rsp_q.size();
    int d0;
    spur_rand  = 32'hDEAD_BEEF;
    spur_valid = 1'b1;
    tick();
    spur_valid = 1'b0;
    tick();
    total++; if (busy !== 1'b0 || rsp_q.size() != r0 || rsp_data === 32'hDEAD_BEEF) begin bad++; $display("FAIL spur_idle got=busy%0b rsp%0d data%h want=busy0 rsp0", busy, rsp_q.size() - r0, rsp_data); end
    d0 = model_steps;
    set_req(0, 32'h6666_6666, 8'd1);
    req_valid[0] = 1'b1;
    tick();
    req_valid[0] = 1'b0;
    #1;
    total++; if (core_load !== 1'b1) begin bad++; $display("FAIL spur_in_load got=load%0b want=1", core_load); end
    spur_valid = 1'b1;
    tick();
    spur_valid = 1'b0;
    #1;
    total++; if (core_step !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL spur_load_fsm got=step%0b rv%0b want=1/0", core_step, rsp_valid); end
    wait_idle(100);
    total++; if (rsp_q.size() - r0 != 1) begin bad++; $display("FAIL spur_rsp_count got=%0d want=1", rsp_q.size() - r0); end
    else begin
      total++; if (rsp_q[r0].data !== 32'hC0DE_0000 + 32'(d0) || rsp_q[r0].last !== 1'b1) begin bad++; $display("FAIL spur_rsp_data got=%h last%0b want=%h last1", rsp_q[r0].data, rsp_q[r0].last, 32'hC0DE_0000 + 32'(d0)); end
    end
    $display("test_spurious done");
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_round_robin();
    test_zero_len();
    test_timeout();
    test_reset_midburst();
    test_spurious();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
